// File: rtl/seven_seg_scan_decoder_pkg.sv
// Shared 7-segment pattern and BCD code constants for the encoder and scan decoder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seven_seg_pkg;

    // Segment patterns in {a,b,c,d,e,f,g} order, bit6 = a, active-high
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1110011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-decimal BCD codes for a dark digit and an unrecognised pattern
    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

endpackage

// File: rtl/seven_seg_scan_decoder_pattern_decode.sv
// Maps one 7-segment pattern back to its BCD digit, flagging illegal patterns.
// Latency: purely combinational.
// Backpressure: none.
module seg7_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       err
);

    // Table lookup; anything not in the table is reported as an error digit
    always_comb begin
        bcd = BCD_ERR;
        err = 1'b1;
        case (seg)
            SEG_0:     begin bcd = 4'd0;      err = 1'b0; end
            SEG_1:     begin bcd = 4'd1;      err = 1'b0; end
            SEG_2:     begin bcd = 4'd2;      err = 1'b0; end
            SEG_3:     begin bcd = 4'd3;      err = 1'b0; end
            SEG_4:     begin bcd = 4'd4;      err = 1'b0; end
            SEG_5:     begin bcd = 4'd5;      err = 1'b0; end
            SEG_6:     begin bcd = 4'd6;      err = 1'b0; end
            SEG_7:     begin bcd = 4'd7;      err = 1'b0; end
            SEG_8:     begin bcd = 4'd8;      err = 1'b0; end
            SEG_9:     begin bcd = 4'd9;      err = 1'b0; end
            SEG_BLANK: begin bcd = BCD_BLANK; err = 1'b0; end
            default:   begin bcd = BCD_ERR;   err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Samples a multiplexed 7-segment bus, debounces each digit dwell and assembles NDIG-digit frames.
// Latency: input stable -> capture SYNC_STAGES+STABLE_CYCLES-1 cycles; last capture -> frame_valid 1 cycle.
// Backpressure: frame held stable until frame_ready; a frame completing while one is pending is dropped with an overrun pulse.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_in,
    input  logic [NDIG-1:0]     dig_sel,
    output logic [4*NDIG-1:0]   frame_bcd,
    output logic [NDIG-1:0]     frame_err,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [SYNC_STAGES-1:0][6:0]      seg_sync;
    logic [SYNC_STAGES-1:0][NDIG-1:0] sel_sync;
    logic [6:0]        s_seg;
    logic [NDIG-1:0]   s_sel;
    logic [6:0]        prev_seg;
    logic [NDIG-1:0]   prev_sel;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              changed;
    logic              onehot;
    logic [NDIG-1:0]   cap_new;
    logic [NDIG-1:0]   captured;
    logic [4*NDIG-1:0] shadow_bcd;
    logic [NDIG-1:0]   shadow_err;
    logic [3:0]        dec_bcd;
    logic              dec_err;
    logic              frame_done;
    logic              load;

    assign s_seg = seg_sync[SYNC_STAGES-1];
    assign s_sel = sel_sync[SYNC_STAGES-1];

    seg7_pattern_decode u_decode (
        .seg (s_seg),
        .bcd (dec_bcd),
        .err (dec_err)
    );

    // Synchronise the display bus and remember last cycle's sample for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_sync <= '0;
            sel_sync <= '0;
            prev_seg <= '0;
            prev_sel <= '0;
        end else begin
            seg_sync <= {seg_sync[SYNC_STAGES-2:0], seg_in};
            sel_sync <= {sel_sync[SYNC_STAGES-2:0], dig_sel};
            prev_seg <= s_seg;
            prev_sel <= s_sel;
        end
    end

    // Stability count for the sample being looked at now; capture fires exactly once
    // per dwell, on the STABLE_CYCLES-th identical sample
    always_comb begin
        changed = (s_seg != prev_seg) || (s_sel != prev_sel);
        onehot  = (s_sel != '0) && ((s_sel & (s_sel - NDIG'(1))) == '0);
        cnt_nxt = cnt;
        if (changed || !onehot) begin
            cnt_nxt = '0;
        end else if (cnt != CW'(STABLE_CYCLES)) begin
            cnt_nxt = cnt + CW'(1);
        end
        cap_new = '0;
        if (onehot && (cnt_nxt == CW'(STABLE_CYCLES - 1))) begin
            cap_new = s_sel & ~captured;
        end
        frame_done = &captured;
        load       = frame_done && (!frame_valid || frame_ready);
    end

    // Saturating stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Shadow slots: first capture per position wins until the frame completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured   <= '0;
            shadow_bcd <= '0;
            shadow_err <= '0;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (cap_new[i]) begin
                    shadow_bcd[4*i +: 4] <= dec_bcd;
                    shadow_err[i]        <= dec_err;
                end
            end
            if (frame_done) begin
                captured <= '0;
            end else begin
                captured <= captured | cap_new;
            end
        end
    end

    // Output register: load a finished frame if the slot is free or draining this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_bcd   <= '0;
            frame_err   <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= frame_done && !load;
            if (load) begin
                frame_bcd   <= shadow_bcd;
                frame_err   <= shadow_err;
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
module tb_seven_seg_scan_decoder;

    localparam int NDIG = 4;
    localparam int SC   = 8;
    localparam int SS   = 2;
    localparam int FW   = 5 * NDIG;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [6:0]        seg_in;
    logic [NDIG-1:0]   dig_sel;
    logic [4*NDIG-1:0] frame_bcd;
    logic [NDIG-1:0]   frame_err;
    logic              frame_valid;
    logic              frame_ready;
    logic              overrun;

    int total = 0;
    int bad   = 0;

    // Reference model state: digits seen per position, pending output, expectations
    logic [6:0]    legal_pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                      7'b1111111, 7'b1110011};
    logic [3:0]    m_bcd [NDIG];
    logic          m_err [NDIG];
    logic          m_cap [NDIG];
    logic          m_pend;
    logic [FW-1:0] m_held;
    logic [FW-1:0] exp_q [$];
    logic [FW-1:0] got_q [$];
    int            exp_ovr = 0;
    int            ovr_cnt = 0;
    logic [NDIG-1:0] last_sel;
    logic [6:0]      last_seg;

    seven_seg_scan_decoder #(.NDIG(NDIG), .STABLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .frame_bcd   (frame_bcd),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Observe accepted frames and overrun pulses; also check the held frame stays put
    logic            pv = 1'b0;
    logic            pr = 1'b0;
    logic [4*NDIG-1:0] pb = '0;
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) got_q.push_back({frame_bcd, frame_err});
        if (overrun) ovr_cnt++;
        if (rst_n && pv && !pr && frame_valid) begin
            total++;
            if (frame_bcd !== pb) begin
                bad++;
                $display("FAIL hold_stable got=%h exp=%h", frame_bcd, pb);
            end
        end
        pv = frame_valid && rst_n;
        pr = frame_ready;
        pb = frame_bcd;
    end

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (p == legal_pat[i]) return {4'(i), 1'b0};
        if (p == 7'd0) return {4'hF, 1'b0};
        return {4'hE, 1'b1};
    endfunction

    function automatic logic [FW-1:0] model_frame();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < NDIG; i++) begin
            f[NDIG + 4*i +: 4] = m_bcd[i];
            f[i]               = m_err[i];
        end
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NDIG; i++) m_cap[i] = 1'b0;
    endtask

    // One dwell of len cycles on the bus; model records a capture if it was long enough
    task automatic dwell(input logic [NDIG-1:0] sel, input logic [6:0] seg, input int len);
        int pos;
        logic [4:0] d;
        logic all;
        dig_sel = sel;
        seg_in  = seg;
        last_sel = sel;
        last_seg = seg;
        repeat (len) @(posedge clk);
        #1;
        if (len >= SC && $countones(sel) == 1) begin
            pos = 0;
            for (int i = 0; i < NDIG; i++) if (sel[i]) pos = i;
            if (!m_cap[pos]) begin
                d = ref_decode(seg);
                m_bcd[pos] = d[4:1];
                m_err[pos] = d[0];
                m_cap[pos] = 1'b1;
                all = 1'b1;
                for (int i = 0; i < NDIG; i++) if (!m_cap[i]) all = 1'b0;
                if (all) begin
                    model_clear();
                    if (m_pend && !frame_ready) exp_ovr++;
                    else if (frame_ready) exp_q.push_back(model_frame());
                    else begin m_pend = 1'b1; m_held = model_frame(); end
                end
            end
        end
    endtask

    task automatic set_ready(input logic v);
        frame_ready = v;
        if (v && m_pend) begin
            exp_q.push_back(m_held);
            m_pend = 1'b0;
        end
    endtask

    task automatic idle();
        dwell('0, 7'd0, 6);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        seg_in = '0;
        dig_sel = '0;
        frame_ready = 1'b0;
        m_pend = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        total += 4;
        if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", frame_valid); end
        if (frame_bcd !== '0) begin bad++; $display("FAIL reset_bcd got=%h exp=0", frame_bcd); end
        if (frame_err !== '0) begin bad++; $display("FAIL reset_err got=%h exp=0", frame_err); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_scan();
        got_q.delete(); exp_q.delete();
        set_ready(1'b1);
        dwell(4'b0001, 7'b0110000, 12);
        dwell(4'b0010, 7'b1101101, 12);
        dwell(4'b0100, 7'b1111001, 12);
        dwell(4'b1000, 7'b0110011, 12);
        idle();
        total += 3;
        if (got_q.size() != 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", got_q.size()); end
        else begin
            if (got_q[0][FW-1:NDIG] !== 16'h4321) begin bad++; $display("FAIL basic_bcd got=%h exp=4321", got_q[0][FW-1:NDIG]); end
            if (got_q[0][NDIG-1:0] !== '0) begin bad++; $display("FAIL basic_err got=%h exp=0", got_q[0][NDIG-1:0]); end
        end
    endtask

    task automatic test_decode_special();
        got_q.delete(); exp_q.delete();
        dwell(4'b0001, 7'b1110000, 12);
        dwell(4'b0010, 7'b1000000, 12);
        dwell(4'b0100, 7'b0000000, 12);
        dwell(4'b1000, 7'b1110011, 12);
        idle();
        total++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL special_count got=%0d exp=1", got_q.size());
        end else begin
            total += 5;
            if (got_q[0] !== exp_q[0]) begin bad++; $display("FAIL special_frame got=%h exp=%h", got_q[0], exp_q[0]); end
            if (got_q[0][NDIG+8 +: 4] !== 4'hF) begin bad++; $display("FAIL blank_nibble got=%h exp=f", got_q[0][NDIG+8 +: 4]); end
            if (got_q[0][2] !== 1'b0) begin bad++; $display("FAIL blank_err got=%b exp=0", got_q[0][2]); end
            if (got_q[0][NDIG+4 +: 4] !== 4'hE) begin bad++; $display("FAIL illegal_nibble got=%h exp=e", got_q[0][NDIG+4 +: 4]); end
            if (got_q[0][1] !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b exp=1", got_q[0][1]); end
        end
    endtask

    task automatic test_short_dwell();
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < NDIG; i++) dwell(4'(1 << i), legal_pat[i+5], 6);
        idle();
        total += 2;
        if (got_q.size() != 0) begin bad++; $display("FAIL short_frames got=%0d exp=0", got_q.size()); end
        if (frame_valid !== 1'b0) begin bad++; $display("FAIL short_valid got=%b exp=0", frame_valid); end
    endtask

    task automatic test_overrun();
        logic [FW-1:0] first;
        got_q.delete(); exp_q.delete();
        set_ready(1'b0);
        for (int i = 0; i < NDIG; i++) dwell(4'(1 << i), legal_pat[i], 10);
        first = m_held;
        for (int i = 0; i < NDIG; i++) dwell(4'(1 << i), legal_pat[9-i], 10);
        idle();
        total += 3;
        if (frame_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", frame_valid); end
        if ({frame_bcd, frame_err} !== first) begin bad++; $display("FAIL ovr_held got=%h exp=%h", {frame_bcd, frame_err}, first); end
        if (ovr_cnt !== exp_ovr) begin bad++; $display("FAIL ovr_pulses got=%0d exp=%0d", ovr_cnt, exp_ovr); end
        set_ready(1'b1);
        idle();
        total += 2;
        if (frame_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b exp=0", frame_valid); end
        if (got_q.size() != 1 || got_q[0] !== first) begin bad++; $display("FAIL ovr_accept got=%0d frames exp=1 frame %h", got_q.size(), first); end
    endtask

    task automatic test_overlap();
        got_q.delete(); exp_q.delete();
        dwell(4'b0011, 7'b1011011, 12);
        dwell(4'b0100, 7'b1011111, 12);
        dwell(4'b1000, 7'b1111111, 12);
        idle();
        total++;
        if (got_q.size() != 0) begin bad++; $display("FAIL overlap_early got=%0d exp=0", got_q.size()); end
        dwell(4'b0001, 7'b1111110, 12);
        dwell(4'b0010, 7'b0110000, 12);
        idle();
        total++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL overlap_count got=%0d exp=1", got_q.size());
        end else begin
            total += 2;
            if (got_q[0] !== exp_q[0]) begin bad++; $display("FAIL overlap_frame got=%h exp=%h", got_q[0], exp_q[0]); end
            if (got_q[0][NDIG +: 8] !== 8'h10) begin bad++; $display("FAIL overlap_low got=%h exp=10", got_q[0][NDIG +: 8]); end
        end
    endtask

    task automatic test_mid_reset();
        got_q.delete(); exp_q.delete();
        dwell(4'b0001, 7'b1110011, 12);
        dwell(4'b0010, 7'b1110011, 12);
        rst_n = 1'b0;
        model_clear();
        m_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (frame_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", frame_valid); end
        rst_n = 1'b1;
        dwell(4'b0100, 7'b1101101, 12);
        dwell(4'b1000, 7'b1111001, 12);
        idle();
        total++;
        if (got_q.size() != 0) begin bad++; $display("FAIL midrst_stale got=%0d frames exp=0", got_q.size()); end
        dwell(4'b0001, 7'b0110011, 12);
        dwell(4'b0010, 7'b1011011, 12);
        idle();
        total++;
        if (got_q.size() != 1 || got_q[0][FW-1:NDIG] !== 16'h3254) begin
            bad++; $display("FAIL midrst_frame got=%0d frames bcd=%h exp=1 frame 3254", got_q.size(), got_q.size() ? got_q[0][FW-1:NDIG] : 16'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] fa, fb;
        got_q.delete(); exp_q.delete();
        set_ready(1'b0);
        for (int i = 0; i < NDIG; i++) dwell(4'(1 << i), legal_pat[i+1], 10);
        fa = m_held;
        for (int i = 0; i < NDIG-1; i++) dwell(4'(1 << i), legal_pat[i+6], 10);
        // last dwell timed by hand: ready is high only in the cycle the frame completes
        dig_sel = 4'b1000;
        seg_in  = legal_pat[0];
        last_sel = dig_sel;
        last_seg = seg_in;
        m_bcd[3] = 4'd0;
        m_err[3] = 1'b0;
        fb = model_frame();
        model_clear();
        repeat (SS + SC) @(posedge clk);
        #1;
        total++;
        if ({frame_bcd, frame_err} !== fa) begin bad++; $display("FAIL b2b_before got=%h exp=%h", {frame_bcd, frame_err}, fa); end
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        exp_q.push_back(fa);
        m_held = fb;
        m_pend = 1'b1;
        total += 2;
        if (frame_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", frame_valid); end
        if ({frame_bcd, frame_err} !== fb) begin bad++; $display("FAIL b2b_new got=%h exp=%h", {frame_bcd, frame_err}, fb); end
        @(posedge clk);
        #1;
        idle();
        set_ready(1'b1);
        idle();
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_frame%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [NDIG-1:0] sel;
        logic [6:0] seg;
        int r;
        got_q.delete(); exp_q.delete();
        set_ready(1'b1);
        for (int n = 0; n < 160; n++) begin
            r = $urandom_range(0, 99);
            if (r < 85) sel = 4'(1 << $urandom_range(0, NDIG-1));
            else sel = 4'($urandom_range(1, 15));
            r = $urandom_range(0, 99);
            if (r < 60) seg = legal_pat[$urandom_range(0, 9)];
            else if (r < 70) seg = 7'd0;
            else seg = 7'($urandom_range(0, 127));
            if (sel == last_sel && seg == last_seg) dwell('0, 7'd0, 1);
            dwell(sel, seg, $urandom_range(3, 14));
        end
        idle();
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_frame%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        total++;
        if (ovr_cnt !== exp_ovr) begin bad++; $display("FAIL rand_overrun got=%0d exp=%0d", ovr_cnt, exp_ovr); end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_decode_special();
        test_short_dwell();
        test_overrun();
        test_overlap();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
